// File: rtl/booth_pkg.sv
// Shared types and arithmetic helper for the Booth product accumulator.
package booth_pkg;

  localparam int unsigned ProdWDef = 8;
  // Internal width of the helper adder; wide enough for any supported ACC_W.
  localparam int unsigned AddW = 64;

  typedef enum logic [0:0] {
    Accum,
    Hold
  } state_e;

  typedef struct packed {
    logic signed [AddW-1:0] sum;
    logic                   ovf;
  } add_res_t;

  // Adds two sign-extended operands and flags a result outside the signed w-bit range.
  // With sat_en the sum clamps to the w-bit limits; otherwise the caller keeps the low w bits.
  function automatic add_res_t sat_add(input logic signed [AddW-1:0] a,
                                       input logic signed [AddW-1:0] b,
                                       input int unsigned            w,
                                       input logic                   sat_en);
    add_res_t               res;
    logic signed [AddW-1:0] s;
    logic signed [AddW-1:0] hi;
    logic signed [AddW-1:0] lo;
    s       = a + b;
    hi      = $signed((AddW'(1) << (w - 1)) - AddW'(1));
    lo      = ~hi;
    res.ovf = (s > hi) || (s < lo);
    res.sum = s;
    if (sat_en && res.ovf) begin
      res.sum = s[AddW-1] ? lo : hi;
    end
    return res;
  endfunction

endpackage

// File: rtl/booth_mac_accum_if.sv
// Product-in / frame-sum-out handshake bundle for booth_mac_accum.
interface booth_mac_accum_if #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned LEN    = 4
);
  localparam int unsigned CntW = $clog2(LEN + 1);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_product;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_acc;
  logic [CntW-1:0]          out_count;
  logic                     out_ovf;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface

// File: rtl/booth_acc_add.sv
// Combinational sign-extend / add / overflow datapath of the accumulator.
// Saturating arithmetic when BOOTH_MAC_SAT_EN is defined, wrap-around otherwise.
module booth_acc_add
  import booth_pkg::*;
#(
  parameter int unsigned PROD_W = ProdWDef,
  parameter int unsigned ACC_W  = 16
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [PROD_W-1:0] prod_i,
  output logic signed [ACC_W-1:0]  sum_o,
  output logic                     ovf_o
);

`ifdef BOOTH_MAC_SAT_EN
  localparam logic SatEn = 1'b1;
`else
  localparam logic SatEn = 1'b0;
`endif

  add_res_t res;
  logic     unused_hi;

  always_comb begin
    res = sat_add(AddW'(acc_i), AddW'(prod_i), ACC_W, SatEn);
  end

  assign sum_o     = res.sum[ACC_W-1:0];
  assign ovf_o     = res.ovf;
  assign unused_hi = ^res.sum[AddW-1:ACC_W];

endmodule

// File: rtl/booth_mac_accum.sv
// Accumulates fixed-length (or in_last-terminated) frames of signed products into one sum.
// Optional BOOTH_MAC_SAT_EN selects saturating accumulation.
module booth_mac_accum
  import booth_pkg::*;
#(
  parameter int unsigned PROD_W = ProdWDef,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned LEN    = 4
) (
  input logic               clk,
  input logic               rst_n,
  input logic               clear,
  booth_mac_accum_if.slave  bus
);

  localparam int unsigned CntW = $clog2(LEN + 1);

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CntW-1:0]         cnt_q;
  logic                    ovf_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic signed [ACC_W-1:0] out_acc_q;
  logic [CntW-1:0]         out_count_q;
  logic                    out_ovf_q;

  logic signed [ACC_W-1:0] sum;
  logic                    beat_ovf;
  logic                    accept;
  logic                    frame_end;

  booth_acc_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc_i  (acc_q),
    .prod_i (bus.in_product),
    .sum_o  (sum),
    .ovf_o  (beat_ovf)
  );

  assign accept    = bus.in_valid & in_ready_q;
  assign frame_end = accept & ((cnt_q == CntW'(LEN - 1)) | bus.in_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= Accum;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else if (clear) begin
      // Result registers keep their last values; they are don't-care while out_valid is low.
      state_q     <= Accum;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        Accum: begin
          in_ready_q <= 1'b1;
          if (frame_end) begin
            out_acc_q   <= sum;
            out_count_q <= cnt_q + CntW'(1);
            out_ovf_q   <= ovf_q | beat_ovf;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            state_q     <= Hold;
          end else if (accept) begin
            acc_q <= sum;
            cnt_q <= cnt_q + CntW'(1);
            ovf_q <= ovf_q | beat_ovf;
          end
        end
        Hold: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= Accum;
          end
        end
        default: state_q <= Accum;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_booth_mac_accum.sv
// Self-checking bench for booth_mac_accum: vector table, corner sequences, random vs. model.
module tb_booth_mac_accum;

  localparam int unsigned BW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  booth_mac_accum_if #(.PROD_W(8), .ACC_W(16), .LEN(4)) ifa ();
  booth_mac_accum_if #(.PROD_W(8), .ACC_W(BW), .LEN(4)) ifb ();

  booth_mac_accum #(.PROD_W(8), .ACC_W(16), .LEN(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (ifa)
  );

  booth_mac_accum #(.PROD_W(8), .ACC_W(BW), .LEN(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (ifb)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int n;
    int p[4];
    bit last;
    int acc;
    int cnt;
  } vec_t;

  vec_t vecs[6];

  // Random-phase reference state
  int   m_frame[$];
  bit   m_ready, m_valid, m_ovf, pending;
  int   m_acc, m_cnt;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Signed sum of a frame in w bits, wrapping or saturating on each overflowing beat.
  function automatic void frame_res(input int q[$], input int w, output int acc, output bit ovf);
    longint lim = longint'(1) << (w - 1);
    longint a = 0;
    longint s;
    ovf = 1'b0;
    foreach (q[i]) begin
      s = a + q[i];
      if (s >= lim || s < -lim) begin
        ovf = 1'b1;
`ifdef BOOTH_MAC_SAT_EN
        s = (s >= lim) ? lim - 1 : -lim;
`else
        s = (s >= lim) ? s - 2 * lim : s + 2 * lim;
`endif
      end
      a = s;
    end
    acc = int'(a);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_a(input int p, input bit last);
    int n = 0;
    ifa.in_valid = 1'b1;
    ifa.in_product = 8'(p);
    ifa.in_last = last;
    while (!ifa.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("push_a_timeout", 0, 1);
    @(negedge clk);
    ifa.in_valid = 1'b0;
    ifa.in_last = 1'b0;
  endtask

  task automatic push_b(input int p, input bit last);
    int n = 0;
    ifb.in_valid = 1'b1;
    ifb.in_product = 8'(p);
    ifb.in_last = last;
    while (!ifb.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("push_b_timeout", 0, 1);
    @(negedge clk);
    ifb.in_valid = 1'b0;
    ifb.in_last = 1'b0;
  endtask

  task automatic pop_a();
    ifa.out_ready = 1'b1;
    @(negedge clk);
    ifa.out_ready = 1'b0;
    chk("pop_out_valid", ifa.out_valid, 0);
    chk("pop_in_ready", ifa.in_ready, 1);
  endtask

  initial begin
    vecs[0] = '{4, '{15, -14, 49, 64}, 1'b0, 114, 4};
    vecs[1] = '{2, '{10, 20, 0, 0}, 1'b1, 30, 2};
    vecs[2] = '{4, '{-128, -128, -128, -128}, 1'b0, -512, 4};
    vecs[3] = '{4, '{127, 127, 127, 127}, 1'b0, 508, 4};
    vecs[4] = '{1, '{-5, 0, 0, 0}, 1'b1, -5, 1};
    vecs[5] = '{3, '{100, -1, -100, 0}, 1'b1, -1, 3};

    ifa.in_valid = 0; ifa.in_product = 0; ifa.in_last = 0; ifa.out_ready = 0;
    ifb.in_valid = 0; ifb.in_product = 0; ifb.in_last = 0; ifb.out_ready = 0;

    // Reset values
    #1;
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_acc", $signed(ifa.out_acc), 0);
    chk("rst_out_count", ifa.out_count, 0);
    chk("rst_out_ovf", ifa.out_ovf, 0);
    chk("rst_b_out_valid", ifb.out_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_after", ifa.in_ready, 1);

    // Table of frames, applied back-to-back
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        push_a(vecs[v].p[k], vecs[v].last && (k == vecs[v].n - 1));
      end
      chk("vec_out_valid", ifa.out_valid, 1);
      chk("vec_out_acc", $signed(ifa.out_acc), vecs[v].acc);
      chk("vec_out_count", ifa.out_count, vecs[v].cnt);
      chk("vec_out_ovf", ifa.out_ovf, 0);
      chk("vec_in_ready_hold", ifa.in_ready, 0);
      pop_a();
    end

    // Stall in HOLD with a product waiting upstream
    push_a(1, 0); push_a(2, 0); push_a(3, 0); push_a(4, 0);
    ifa.in_valid = 1'b1; ifa.in_product = 8'(7); ifa.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", ifa.out_valid, 1);
      chk("stall_out_acc", $signed(ifa.out_acc), 10);
      chk("stall_in_ready", ifa.in_ready, 0);
      @(negedge clk);
    end
    ifa.out_ready = 1'b1;
    @(negedge clk);
    ifa.out_ready = 1'b0;
    chk("stall_rel_out_valid", ifa.out_valid, 0);
    chk("stall_rel_in_ready", ifa.in_ready, 1);
    @(negedge clk);
    ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
    chk("stall_next_valid", ifa.out_valid, 1);
    chk("stall_next_acc", $signed(ifa.out_acc), 7);
    chk("stall_next_count", ifa.out_count, 1);
    pop_a();

    // Clear mid-frame, with a beat offered in the clear cycle
    push_a(5, 0); push_a(6, 0);
    clear = 1'b1; ifa.in_valid = 1'b1; ifa.in_product = 8'(100);
    @(negedge clk);
    clear = 1'b0; ifa.in_valid = 1'b0;
    chk("clr_out_valid", ifa.out_valid, 0);
    chk("clr_in_ready", ifa.in_ready, 1);
    push_a(1, 0); push_a(1, 0); push_a(1, 0);
    chk("clr_no_early_result", ifa.out_valid, 0);
    push_a(1, 0);
    chk("clr_out_valid2", ifa.out_valid, 1);
    chk("clr_out_acc", $signed(ifa.out_acc), 4);
    chk("clr_out_count", ifa.out_count, 4);
    pop_a();
    // Clear drops a pending result
    push_a(9, 1);
    chk("clrh_valid_before", ifa.out_valid, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clrh_out_valid", ifa.out_valid, 0);
    push_a(2, 1);
    chk("clrh_next_acc", $signed(ifa.out_acc), 2);
    pop_a();

    // Narrow accumulator: largest non-overflowing sum, then positive and negative overflow
    push_b(127, 0); push_b(127, 1);
    chk("b_fit_acc", $signed(ifb.out_acc), 254);
    chk("b_fit_ovf", ifb.out_ovf, 0);
    ifb.out_ready = 1'b1; @(negedge clk); ifb.out_ready = 1'b0;
    push_b(127, 0); push_b(127, 0); push_b(127, 1);
`ifdef BOOTH_MAC_SAT_EN
    chk("b_pos_acc", $signed(ifb.out_acc), 255);
`else
    chk("b_pos_acc", $signed(ifb.out_acc), -131);
`endif
    chk("b_pos_ovf", ifb.out_ovf, 1);
    chk("b_pos_count", ifb.out_count, 3);
    ifb.out_ready = 1'b1; @(negedge clk); ifb.out_ready = 1'b0;
    push_b(-128, 0); push_b(-128, 0); push_b(-128, 0); push_b(127, 0);
`ifdef BOOTH_MAC_SAT_EN
    chk("b_neg_acc", $signed(ifb.out_acc), -129);
`else
    chk("b_neg_acc", $signed(ifb.out_acc), 255);
`endif
    chk("b_neg_ovf", ifb.out_ovf, 1);
    ifb.out_ready = 1'b1; @(negedge clk); ifb.out_ready = 1'b0;
    chk("b_next_ovf_clear_valid", ifb.out_valid, 0);

    // Random traffic against the frame-level model
    m_frame.delete(); m_ready = 1; m_valid = 0; pending = 0;
    for (int c = 0; c < 600; c++) begin
      chk("rnd_in_ready", ifa.in_ready, m_ready);
      chk("rnd_out_valid", ifa.out_valid, m_valid);
      if (m_valid) begin
        chk("rnd_out_acc", $signed(ifa.out_acc), m_acc);
        chk("rnd_out_count", ifa.out_count, m_cnt);
        chk("rnd_out_ovf", ifa.out_ovf, m_ovf);
      end
      if (!pending) begin
        ifa.in_valid = ($urandom_range(0, 9) < 7);
        ifa.in_product = 8'($urandom_range(0, 255));
        ifa.in_last = ($urandom_range(0, 4) == 0);
      end
      ifa.out_ready = $urandom_range(0, 1) == 1;
      clear = ($urandom_range(0, 49) == 0);
      if (clear) begin
        m_frame.delete(); m_valid = 0; m_ready = 1; pending = 0;
      end else if (m_ready) begin
        pending = 0;
        if (ifa.in_valid) begin
          m_frame.push_back(int'($signed(ifa.in_product)));
          if (m_frame.size() == 4 || ifa.in_last) begin
            m_cnt = m_frame.size();
            frame_res(m_frame, 16, m_acc, m_ovf);
            m_frame.delete(); m_valid = 1; m_ready = 0;
          end
        end
      end else begin
        pending = ifa.in_valid;
        if (ifa.out_ready) begin m_valid = 0; m_ready = 1; end
      end
      @(negedge clk);
    end
    clear = 1'b1; ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
    @(negedge clk);
    clear = 1'b0;

    // Asynchronous reset while a result is held
    push_a(10, 0); push_a(20, 1);
    chk("arst_valid_before", ifa.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", ifa.out_valid, 0);
    chk("arst_out_acc", $signed(ifa.out_acc), 0);
    chk("arst_out_count", ifa.out_count, 0);
    chk("arst_out_ovf", ifa.out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", ifa.in_ready, 1);
    push_a(3, 1);
    chk("arst_fresh_acc", $signed(ifa.out_acc), 3);
    chk("arst_fresh_count", ifa.out_count, 1);
    pop_a();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
